// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and execute stage.
// Opcodes, operand/result types and divider iteration count.
package instr_register_pkg;

    localparam int OP_W       = 32;
    localparam int RES_W      = 64;
    localparam int DIV_CYCLES = OP_W;

    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    typedef logic signed [OP_W-1:0]  operand_t;
    typedef logic signed [RES_W-1:0] operand_res_t;

    typedef struct packed {
        opcode_t  opcode;
        operand_t op_a;
        operand_t op_b;
    } instruction_t;

    function automatic logic is_div_op(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

    function automatic operand_res_t sext(input operand_t v);
        return {{(RES_W-OP_W){v[OP_W-1]}}, v};
    endfunction

endpackage

// File: rtl/instr_div_iter.sv
// Iterative signed restoring divider, one quotient bit per cycle.
// Results are valid combinationally while done is high.
module instr_div_iter
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  operand_t     dividend,
    input  operand_t     divisor,
    output logic         busy,
    output logic         done,
    output operand_res_t quotient,
    output operand_res_t remainder
);

    localparam int CW = $clog2(DIV_CYCLES);

    logic [CW-1:0]   cnt;
    logic [OP_W-1:0] q_r;
    logic [OP_W-1:0] d_r;
    logic [OP_W:0]   r_r;
    logic            neg_q;
    logic            neg_r;

    logic [OP_W:0]    shifted;
    logic [OP_W:0]    diff;
    logic [OP_W:0]    r_nxt;
    logic [OP_W-1:0]  q_nxt;
    logic [RES_W-1:0] q_mag;
    logic [RES_W-1:0] r_mag;

    // One restoring step plus sign fix-up of the final iteration
    always_comb begin
        shifted = {r_r[OP_W-1:0], q_r[OP_W-1]};
        diff    = shifted - {1'b0, d_r};
        if (!diff[OP_W]) begin
            r_nxt = diff;
            q_nxt = {q_r[OP_W-2:0], 1'b1};
        end else begin
            r_nxt = shifted;
            q_nxt = {q_r[OP_W-2:0], 1'b0};
        end
        q_mag     = {{(RES_W-OP_W){1'b0}}, q_nxt};
        r_mag     = {{(RES_W-OP_W){1'b0}}, r_nxt[OP_W-1:0]};
        quotient  = neg_q ? -q_mag : q_mag;
        remainder = neg_r ? -r_mag : r_mag;
        done      = busy && (cnt == CW'(DIV_CYCLES-1));
    end

    // Load magnitudes on start, then iterate until the last bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            q_r   <= '0;
            d_r   <= '0;
            r_r   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            q_r   <= dividend[OP_W-1] ? -dividend : dividend;
            d_r   <= divisor[OP_W-1]  ? -divisor  : divisor;
            r_r   <= '0;
            neg_q <= dividend[OP_W-1] ^ divisor[OP_W-1];
            neg_r <= dividend[OP_W-1];
            busy  <= 1'b1;
        end else if (busy) begin
            q_r <= q_nxt;
            r_r <= r_nxt;
            cnt <= cnt + CW'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/instr_exec_unit.sv
// Execute stage: single-cycle ALU ops plus 32-cycle signed DIV/MOD.
// Define EXEC_STATS_EN to add issue/busy/div-by-zero counters.
module instr_exec_unit
    import instr_register_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  opcode_t      in_opcode,
    input  operand_t     in_op_a,
    input  operand_t     in_op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output operand_res_t out_result,
    output opcode_t      out_opcode,
    output logic         out_div_zero
`ifdef EXEC_STATS_EN
    ,
    output logic [31:0]  stat_issued,
    output logic [31:0]  stat_div_busy_cycles,
    output logic [15:0]  stat_div_zero
`endif
);

    typedef enum logic {IDLE, DIV_RUN} state_t;

    state_t       state;
    state_t       state_nxt;
    opcode_t      div_op;
    operand_res_t fast_res;
    operand_res_t div_quo;
    operand_res_t div_rem;
    logic         accept;
    logic         div_start;
    logic         div_zero;
    logic         div_busy;
    logic         div_done;

    // Handshake and classification of the incoming instruction
    always_comb begin
        in_ready  = !reset && (state == IDLE) && (!out_valid || out_ready);
        accept    = in_valid && in_ready;
        div_start = accept && is_div_op(in_opcode) && (in_op_b != '0);
        div_zero  = accept && is_div_op(in_opcode) && (in_op_b == '0);
    end

    // Single-cycle result; DIV/MOD here only covers a zero divisor
    always_comb begin
        fast_res = '0;
        unique case (in_opcode)
            ZERO:  fast_res = '0;
            PASSA: fast_res = sext(in_op_a);
            PASSB: fast_res = sext(in_op_b);
            ADD:   fast_res = sext(in_op_a) + sext(in_op_b);
            SUB:   fast_res = sext(in_op_a) - sext(in_op_b);
            MULT:  fast_res = sext(in_op_a) * sext(in_op_b);
            DIV:   fast_res = '0;
            MOD:   fast_res = '0;
        endcase
    end

    instr_div_iter u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (in_op_a),
        .divisor   (in_op_b),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    // Next-state: enter DIV_RUN on a real divide, leave on completion
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (div_start) state_nxt = DIV_RUN;
            DIV_RUN: if (div_done)  state_nxt = IDLE;
        endcase
    end

    // State register and opcode remembered for the divide echo
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            div_op <= ZERO;
        end else begin
            state <= state_nxt;
            if (div_start) begin
                div_op <= in_opcode;
            end
        end
    end

    // Output slot: load fast or divider result, else drain on ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_opcode   <= ZERO;
            out_div_zero <= 1'b0;
        end else if (accept && !div_start) begin
            out_valid    <= 1'b1;
            out_result   <= fast_res;
            out_opcode   <= in_opcode;
            out_div_zero <= div_zero;
        end else if (div_done) begin
            out_valid    <= 1'b1;
            out_result   <= (div_op == MOD) ? div_rem : div_quo;
            out_opcode   <= div_op;
            out_div_zero <= 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef EXEC_STATS_EN
    // Saturating activity counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued          <= '0;
            stat_div_busy_cycles <= '0;
            stat_div_zero        <= '0;
        end else begin
            if (accept && (stat_issued != '1)) begin
                stat_issued <= stat_issued + 32'd1;
            end
            if ((state == DIV_RUN) && (stat_div_busy_cycles != '1)) begin
                stat_div_busy_cycles <= stat_div_busy_cycles + 32'd1;
            end
            if (div_zero && (stat_div_zero != '1)) begin
                stat_div_zero <= stat_div_zero + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_exec_unit.sv
// Bench for instr_exec_unit: directed cases then random traffic
// against an arithmetic reference with cycle-level timing.
module tb_instr_exec_unit;
    import instr_register_pkg::*;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    opcode_t      in_opcode = ZERO;
    operand_t     in_op_a = '0;
    operand_t     in_op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    operand_res_t out_result;
    opcode_t      out_opcode;
    logic         out_div_zero;
`ifdef EXEC_STATS_EN
    logic [31:0]  stat_issued;
    logic [31:0]  stat_div_busy_cycles;
    logic [15:0]  stat_div_zero;
`endif

    always #5 clk = ~clk;

    instr_exec_unit dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_op_a      (in_op_a),
        .in_op_b      (in_op_b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_opcode   (out_opcode),
        .out_div_zero (out_div_zero)
`ifdef EXEC_STATS_EN
        ,
        .stat_issued          (stat_issued),
        .stat_div_busy_cycles (stat_div_busy_cycles),
        .stat_div_zero        (stat_div_zero)
`endif
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference state: visible result slot and pending divide countdown
    bit      mv = 0;
    longint  mres = 0;
    opcode_t mop = ZERO;
    bit      mdz = 0;
    int      busy = 0;
    longint  pres = 0;
    opcode_t pop = ZERO;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic longint ref_result(input opcode_t op, input int a,
                                          input int b);
        longint la = longint'(a);
        longint lb = longint'(b);
        case (op)
            ZERO:    return 0;
            PASSA:   return la;
            PASSB:   return lb;
            ADD:     return la + lb;
            SUB:     return la - lb;
            MULT:    return la * lb;
            DIV:     return (b == 0) ? 0 : la / lb;
            default: return (b == 0) ? 0 : la % lb;
        endcase
    endfunction

    function automatic bit is_dv(input opcode_t op);
        return (op == DIV) || (op == MOD);
    endfunction

    // One clock: drive at negedge, check, then advance the reference
    task automatic cycle(input bit v, input opcode_t op, input int a,
                         input int b, input bit rdy);
        bit exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_opcode = op;
        in_op_a   = a;
        in_op_b   = b;
        out_ready = rdy;
        #1;
        exp_rdy = !reset && (busy == 0) && (!mv || rdy);
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(mv));
        if (mv) begin
            check("result", out_result, mres);
            check("opcode", 64'(out_opcode), 64'(mop));
            check("div_zero", 64'(out_div_zero), 64'(mdz));
        end
        @(posedge clk);
        if (reset) begin
            mv   = 0;
            busy = 0;
        end else if (v && exp_rdy) begin
            if (is_dv(op) && b != 0) begin
                busy = DIV_CYCLES;
                pres = ref_result(op, a, b);
                pop  = op;
                mv   = 0;
            end else begin
                mv   = 1;
                mres = ref_result(op, a, b);
                mop  = op;
                mdz  = is_dv(op);
            end
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                mv   = 1;
                mres = pres;
                mop  = pop;
                mdz  = 0;
            end
        end else if (mv && rdy) begin
            mv = 0;
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(0, ZERO, 0, 0, rdy);
    endtask

    function automatic int pick();
        case ($urandom_range(0, 7))
            0:       return 0;
            1:       return 1;
            2:       return -1;
            3:       return int'(32'h8000_0000);
            4:       return int'(32'h7fff_ffff);
            5:       return int'($urandom_range(0, 20)) - 10;
            default: return int'($urandom);
        endcase
    endfunction

    initial begin
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", out_result, 64'd0);
        check("rst_opcode", 64'(out_opcode), 64'(ZERO));
        check("rst_div_zero", 64'(out_div_zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        idle(2, 1);
        @(negedge clk);
        reset = 1'b0;

        cycle(1, ADD, 7, -3, 1);
        idle(2, 1);

        cycle(1, MULT, -15, 15, 1);
        cycle(1, PASSB, 0, 9, 1);
        idle(2, 1);

        cycle(1, DIV, -15, 4, 1);
        idle(33, 1);
        cycle(1, MOD, -15, 4, 1);
        idle(33, 1);

        cycle(1, DIV, int'(32'h8000_0000), -1, 1);
        idle(33, 1);

        cycle(1, DIV, 12, 0, 1);
        cycle(1, MOD, 12, 0, 1);
        idle(2, 1);

        cycle(1, ADD, 5, 5, 0);
        idle(3, 0);
        idle(2, 1);

        cycle(1, DIV, 100, 7, 1);
        idle(10, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        idle(2, 1);
        @(negedge clk);
        reset = 1'b0;
        cycle(1, ADD, 1, 1, 1);
        idle(2, 1);

        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 9) < 7,
                  opcode_t'($urandom_range(0, 7)),
                  pick(), pick(),
                  $urandom_range(0, 9) < 7);
        end
        idle(40, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
